stream_fifo_io: RTL and testbench
=================================

Name: stream_fifo_io

Overview:
- Parametrised successor of the two-buffer stream input/output block: a first-word-fall-through stream buffer of configurable depth between an upstream and a downstream valid/ready interface.
- Adds fill level, programmable almost-full/almost-empty flags, synchronous flush and a post-reset in_ready hold-off.
- Sits between AXI-stream IPs and user IP, or in front of/behind dual-clock FIFO macros on the same clock domain.
- No combinational path from out_ready to in_ready.

Parameters:
- DATA_WIDTH, 32, width of in_data/out_data in bits.
- DEPTH, 4, number of entries; power of two, 2..1024.
- AFULL_LEVEL, DEPTH-1, level at or above which almost_full=1; range 1..DEPTH.
- AEMPTY_LEVEL, 1, level at or below which almost_empty=1; range 0..DEPTH-1.
- IN_READY_LOW_CYCLES, 0, extra cycles in_ready stays 0 after reset release; range >=0.
- OUT_ZERO, "FALSE", "TRUE" forces out_data=0 while out_valid=0; "FALSE" shows the stale entry at the read pointer.

Ports:
- clock  in  1  common clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents without hold-off.
- in_data  in  DATA_WIDTH  upstream data.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  buffer accepts data.
- out_data  out  DATA_WIDTH  downstream data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts data.
- level  out  LW=$clog2(DEPTH+1)  number of stored entries.
- almost_full  out  1  level >= AFULL_LEVEL.
- almost_empty  out  1  level <= AEMPTY_LEVEL.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array. wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap modulo DEPTH. level is a registered counter.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Each is evaluated at the rising edge.
- in_ready = ~hold & (level != DEPTH). It depends only on registered state.
  - When full, in_ready=0 even if a pop happens in the same cycle. The freed slot is offered the next cycle.
- out_valid = (level != 0). out_data = mem[rd_ptr], or 0 if OUT_ZERO="TRUE" and level==0.
- Latency: a word pushed at edge k appears with out_valid=1 in the cycle after edge k (one cycle).
  - Continuous streaming with out_ready=1 gives one word per cycle with no bubbles.
- Level update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - neither: hold.
- Empty: pop is impossible because out_valid=0. A push into an empty buffer makes out_valid=1 next cycle.
- Full: level==DEPTH, in_ready=0, pop allowed.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gap or data loss.
- Flags: almost_full and almost_empty are decoded combinationally from the registered level.
- Reset (priority 1):
  - wr_ptr, rd_ptr and level clear to 0.
  - out_valid=0, in_ready=0, almost_empty=1, almost_full=0.
  - out_data=0. Storage is cleared to 0.
  - A reset asserted mid-stream discards all contents in the same edge.
- Hold-off after reset release:
  - hold counter loads IN_READY_LOW_CYCLES while reset=1.
  - in_ready first goes 1 at IN_READY_LOW_CYCLES+1 cycles after the first edge with reset=0.
  - With IN_READY_LOW_CYCLES=0, in_ready goes 1 one cycle after reset release.
- Flush (priority 2, over push/pop):
  - Pointers and level clear. A push or pop in the same cycle is ignored: the upstream word is dropped and the downstream word is discarded.
  - Storage is not cleared. The hold counter is unaffected, so in_ready is not forced low.
- Signals are X-free after reset. All outputs are defined for every input combination.

Optional Feature:
- Macro STREAM_FIFO_IO_LAST_EN.
- Defined:
  - Adds ports in_last (in, 1) and out_last (out, 1).
  - in_last is stored alongside each entry and presented as out_last with out_data.
  - out_last obeys the same OUT_ZERO rule as out_data.
  - Adds output packets (out, 16): a saturating count of stored entries with last=1. It increments on push of a last word, decrements on pop of a last word, is unchanged when both occur together, and clears on reset/flush.
- Not defined: no last ports, no packets counter; the datapath is DATA_WIDTH only.

Test Plan:
- Reset/hold-off: DEPTH=4, IN_READY_LOW_CYCLES=3. Release reset at cycle 0 -> in_ready=0 through cycle 3, 1 at cycle 4; out_valid=0, level=0, almost_empty=1 throughout.
- Streaming: in_valid=1 with data 1..100 and out_ready=1 continuously -> out_data 1..100 in order, one per cycle; first out_valid one cycle after first push; level stays 1.
- Fill/full: out_ready=0, push 0xA0..0xA3 -> level=4, in_ready=0, almost_full=1 (AFULL_LEVEL=3 from level 3). Then out_ready=1 for one cycle -> pops 0xA0, level=3, in_ready back to 1 next cycle.
- Wrap and simultaneous: random in_valid/out_ready at 50% for 10000 cycles, DEPTH=4 -> scoreboard matches exactly, no loss or duplication; level never exceeds 4; push+pop cycles leave level unchanged.
- Flush mid-operation: level=3 with flush=1 and in_valid=1 in the same cycle -> next cycle level=0, out_valid=0, that input word not stored, in_ready=1. With OUT_ZERO="TRUE", out_data=0.
- Reset mid-stream with STREAM_FIFO_IO_LAST_EN: packets=2 and level=3, assert reset for one cycle -> level=0, packets=0, out_last=0, in_ready=0 until the hold-off expires.

Source files
------------

// File: rtl/stream_fifo_io.sv
// stream_fifo_io: first-word-fall-through stream buffer of DEPTH entries between
// an upstream and a downstream valid/ready interface.
//   clock, reset (sync, active-high), flush (sync clear of contents)
//   in_data/in_valid/in_ready     upstream handshake
//   out_data/out_valid/out_ready  downstream handshake
//   level, almost_full, almost_empty  fill status
// Optional macro STREAM_FIFO_IO_LAST_EN adds in_last/out_last and the packets counter.
module stream_fifo_io #(
   parameter int    DATA_WIDTH          = 32,
   parameter int    DEPTH               = 4,
   parameter int    AFULL_LEVEL         = DEPTH - 1,
   parameter int    AEMPTY_LEVEL        = 1,
   parameter int    IN_READY_LOW_CYCLES = 0,
   parameter string OUT_ZERO            = "FALSE",
   localparam int   LW                  = $clog2(DEPTH + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
`ifdef STREAM_FIFO_IO_LAST_EN
   input  logic                  in_last,
   output logic                  out_last,
   output logic [15:0]           packets,
`endif
   output logic [LW-1:0]         level,
   output logic                  almost_full,
   output logic                  almost_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int HW = $clog2(IN_READY_LOW_CYCLES + 2);
`ifdef STREAM_FIFO_IO_LAST_EN
   localparam int EW = DATA_WIDTH + 1;
`else
   localparam int EW = DATA_WIDTH;
`endif
   localparam bit OZ = (OUT_ZERO == "TRUE");

   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] wr_word, rd_word;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [HW-1:0] hold_cnt;
   logic          hold, push, pop;

   // in_ready only sees registered state, so out_ready never reaches it combinationally
   assign in_ready     = ~hold & (level != LW'(DEPTH));
   assign out_valid    = (level != '0);
   assign push         = in_valid & in_ready;
   assign pop          = out_valid & out_ready;
   assign almost_full  = (level >= LW'(AFULL_LEVEL));
   assign almost_empty = (level <= LW'(AEMPTY_LEVEL));
   assign rd_word      = (OZ && level == '0) ? '0 : mem[rd_ptr];
   assign out_data     = rd_word[DATA_WIDTH-1:0];
`ifdef STREAM_FIFO_IO_LAST_EN
   assign wr_word      = {in_last, in_data};
   assign out_last     = rd_word[DATA_WIDTH];
`else
   assign wr_word      = in_data;
`endif

   // hold-off: counter preloads during reset, in_ready released once it has run out
   always_ff @(posedge clock) begin
      if (reset) begin
         hold     <= 1'b1;
         hold_cnt <= HW'(IN_READY_LOW_CYCLES);
      end else if (hold) begin
         if (hold_cnt == '0) hold <= 1'b0;
         else hold_cnt <= hold_cnt - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_word;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(push) - LW'(pop);
      end
   end

`ifdef STREAM_FIFO_IO_LAST_EN
   logic push_last, pop_last;
   assign push_last = push & in_last;
   assign pop_last  = pop & mem[rd_ptr][DATA_WIDTH];

   always_ff @(posedge clock) begin
      if (reset || flush) packets <= '0;
      else if (push_last && !pop_last && packets != 16'hFFFF) packets <= packets + 1'b1;
      else if (pop_last && !push_last && packets != 16'h0000) packets <= packets - 1'b1;
   end
`endif
endmodule

// File: tb/tb_stream_fifo_io.sv
// tb_stream_fifo_io: scoreboard bench for stream_fifo_io (DEPTH=4, hold-off 3, OUT_ZERO="TRUE").
module tb_stream_fifo_io;
   localparam int DW = 32;
   localparam int D  = 4;
   localparam int N  = 3;
   localparam int LW = $clog2(D + 1);

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [LW-1:0] level;
   logic          almost_full, almost_empty;
`ifdef STREAM_FIFO_IO_LAST_EN
   logic          in_last = 1'b0;
   logic          out_last;
   logic [15:0]   packets;
`endif

   stream_fifo_io #(
      .DATA_WIDTH(DW), .DEPTH(D), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1),
      .IN_READY_LOW_CYCLES(N), .OUT_ZERO("TRUE")
   ) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef STREAM_FIFO_IO_LAST_EN
      .in_last(in_last), .out_last(out_last), .packets(packets),
`endif
      .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
   );

   always #5 clock = ~clock;

   int          tests = 0;
   int          fails = 0;
   logic [32:0] q[$];
   bit          busy = 1'b1;
   int          hcnt = N;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int last_count();
      int n = 0;
      foreach (q[i]) n += int'(q[i][32]);
      return n;
   endfunction

   // checks the settled outputs against the model, drives one cycle, advances the model
   task automatic cyc(input bit rs, input bit fl, input bit vi, input bit lst, input bit orr, input logic [31:0] d);
      bit rdy, push, pop;
      rdy = !busy && q.size() != D;
      check("in_ready", in_ready, rdy);
      check("out_valid", out_valid, q.size() != 0);
      check("level", level, q.size());
      check("almost_full", almost_full, q.size() >= 3);
      check("almost_empty", almost_empty, q.size() <= 1);
      check("out_data", out_data, q.size() != 0 ? q[0][31:0] : 32'h0);
`ifdef STREAM_FIFO_IO_LAST_EN
      check("out_last", out_last, q.size() != 0 ? q[0][32] : 1'b0);
      check("packets", packets, last_count());
      in_last = lst;
`endif
      reset = rs; flush = fl; in_valid = vi; in_data = d; out_ready = orr;
      push = vi && rdy;
      pop = orr && q.size() != 0;
      @(posedge clock);
      if (rs) begin
         q.delete();
         busy = 1'b1;
         hcnt = N;
      end else begin
         if (busy) begin
            if (hcnt == 0) busy = 1'b0;
            else hcnt--;
         end
         if (fl) q.delete();
         else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back({lst, d});
         end
      end
      @(negedge clock);
   endtask

   initial begin
      @(posedge clock);
      @(negedge clock);
      repeat (2) cyc(1, 0, 0, 0, 0, 0);
      repeat (6) cyc(0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 100; i++) cyc(0, 0, 1, 0, 1, i);
      repeat (2) cyc(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 32'hA0 + i);
      cyc(0, 0, 1, 0, 1, 32'hEE);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 32'hBAD);
      repeat (2) cyc(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10000; i++)
         cyc(0, $urandom_range(63) == 0, $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom);
      repeat (6) cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 1, 1, 0, 32'h11);
      cyc(0, 0, 1, 1, 0, 32'h22);
      cyc(0, 0, 1, 0, 0, 32'h33);
      cyc(1, 0, 0, 0, 0, 0);
      repeat (6) cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 1, 32'h44);
      repeat (2) cyc(0, 0, 0, 0, 1, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
